sar_logic: RTL and testbench

Successive-approximation controller on the consuming end of the clock-generator interface. It takes the sample phase and comparator-ready strobes produced by `clk_gen` and runs the MSB-first binary search. It drives the capacitive-DAC trial code and returns one conversion word per sample window. It runs on the fast internal clock, with all inputs treated as synchronous to it.

---
 rtl/sar_pkg.sv | 16 +
 rtl/sar_edge_det.sv | 25 ++
 rtl/sar_logic.sv | 173 +++++++++++++++++
 tb/tb_sar_logic.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR controller: FSM state encoding and the
// default resolution/timeout constants also used by clk_gen.
package sar_pkg;

  localparam int SAR_NUM_BITS    = 4;
  localparam int SAR_TIMEOUT_CYC = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_TRIAL  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } sar_state_t;

endpackage

// File: rtl/sar_edge_det.sv
// Rise/fall detector for the sample phase, built on a registered copy of
// the input so both strobes are valid in the same cycle the input moves.
module sar_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Previous-cycle copy of the sample phase
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: MSB-first binary search driven by
// clk_gen's sample phase. Define SAR_LOGIC_TIMEOUT_EN to add a comparator timeout.
module sar_logic
  import sar_pkg::*;
#(
  parameter int NUM_BITS    = SAR_NUM_BITS,
  parameter int TIMEOUT_CYC = SAR_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_i,
  input  logic                cmp_ready_i,
  input  logic                cmp_out_i,
  output logic                cmp_start_o,
  output logic [NUM_BITS-1:0] dac_code_o,
  output logic                busy_o,
  output logic [NUM_BITS-1:0] data_o,
  output logic                data_valid_o,
  output logic                overrun_o,
  output logic                timeout_o
);

  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [NUM_BITS-1:0] MSB_CODE = {1'b1, {(NUM_BITS-1){1'b0}}};

  sar_state_t          state_q;
  logic [NUM_BITS-1:0] code_q;
  logic [NUM_BITS-1:0] data_q;
  logic [IDX_W-1:0]    idx_q;
  logic                cmp_start_q;
  logic                busy_q;
  logic                valid_q;
  logic                overrun_q;
  logic                timeout_q;

  logic                rise_s;
  logic                fall_s;
  logic                tmo_s;
  logic                resolve_s;
  logic                bit_val_s;
  logic [IDX_W-1:0]    idx_m1_s;

  function automatic logic [NUM_BITS-1:0] put_bit(input logic [NUM_BITS-1:0] code,
                                                  input logic [IDX_W-1:0]    pos,
                                                  input logic                val);
    logic [NUM_BITS-1:0] res;
    res      = code;
    res[pos] = val;
    return res;
  endfunction

  sar_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (sample_i),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

`ifdef SAR_LOGIC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Counts WAIT cycles; cleared whenever the FSM is outside WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // A real decision in the same cycle beats the timeout
  assign tmo_s = (state_q == ST_WAIT) && !cmp_ready_i &&
                 (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_s = 1'b0;
`endif

  assign resolve_s = cmp_ready_i | tmo_s;
  assign bit_val_s = cmp_ready_i & cmp_out_i;
  assign idx_m1_s  = idx_q - IDX_W'(1);

  // Conversion FSM with its code/index registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      cmp_start_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cmp_start_q <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          code_q  <= '0;
          busy_q  <= rise_s;
          state_q <= rise_s ? ST_SAMPLE : ST_IDLE;
        end
        ST_SAMPLE: begin
          if (fall_s) begin
            state_q     <= ST_TRIAL;
            idx_q       <= IDX_W'(NUM_BITS - 1);
            code_q      <= MSB_CODE;
            cmp_start_q <= 1'b1;
          end else begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_TRIAL: begin
          if (rise_s) begin
            state_q   <= ST_SAMPLE;
            code_q    <= '0;
            overrun_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rise_s) begin
            state_q   <= ST_SAMPLE;
            code_q    <= '0;
            overrun_q <= 1'b1;
          end else if (resolve_s) begin
            timeout_q <= tmo_s;
            if (idx_q == '0) begin
              // The trial code is left as-is; only the result carries bit 0
              state_q <= ST_DONE;
              data_q  <= put_bit(code_q, idx_q, bit_val_s);
              valid_q <= 1'b1;
            end else begin
              state_q     <= ST_TRIAL;
              idx_q       <= idx_m1_s;
              code_q      <= put_bit(put_bit(code_q, idx_q, bit_val_s), idx_m1_s, 1'b1);
              cmp_start_q <= 1'b1;
            end
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          code_q  <= '0;
          busy_q  <= rise_s;
          state_q <= rise_s ? ST_SAMPLE : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          code_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmp_start_o  = cmp_start_q;
  assign dac_code_o   = code_q;
  assign busy_o       = busy_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sar_logic.sv
// Scoreboard bench for sar_logic: randomized conversions against a binary-search
// reference model, plus abort, reset, stray-ready and (optionally) timeout cases.
module tb_sar_logic;

  localparam int NB = 4;

  logic          clk;
  logic          reset;
  logic          sample;
  logic          rsp_ready, rsp_out;
  logic          stray_rdy, stray_out;
  logic          cmp_ready, cmp_out;
  logic          cmp_start_o, busy_o, data_valid_o, overrun_o, timeout_o;
  logic [NB-1:0] dac_code_o, data_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int win_id = 0;
  int seen_win = 0;
  int starts = 0;
  int rsp_delay = 1;
  int exp_ovr = 0, obs_ovr = 0;
  int exp_tmo = 0, obs_tmo = 0;
  bit stray_trial = 1'b0;
  logic [NB-1:0] vin_cur = '0;
  logic [NB-1:0] hold_mask = '0;
  logic [NB-1:0] last_data = '0;

  logic [NB-1:0] exp_code[$];
  logic [NB-1:0] exp_data[$];
  int            exp_lat[$];

  assign cmp_ready = rsp_ready | stray_rdy;
  assign cmp_out   = rsp_ready ? rsp_out : stray_out;

  sar_logic #(.NUM_BITS(NB), .TIMEOUT_CYC(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_i     (sample),
    .cmp_ready_i  (cmp_ready),
    .cmp_out_i    (cmp_out),
    .cmp_start_o  (cmp_start_o),
    .dac_code_o   (dac_code_o),
    .busy_o       (busy_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Comparator model: answers each start after rsp_delay WAIT cycles unless held
  initial begin : responder
    int bitpos;
    rsp_ready = 1'b0;
    rsp_out   = 1'b0;
    forever begin
      @(negedge clk);
      if (win_id != seen_win) begin
        seen_win = win_id;
        starts   = 0;
      end
      if (cmp_start_o) begin
        bitpos = NB - 1 - starts;
        starts++;
        if (stray_trial) begin
          rsp_out   = !(vin_cur >= dac_code_o);
          rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (bitpos < 0 || !hold_mask[bitpos]) begin
          repeat (rsp_delay - 1) begin
            @(posedge clk); #1;
          end
          rsp_out   = (vin_cur >= dac_code_o);
          rsp_ready = 1'b1;
          @(posedge clk); #1;
          rsp_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start or a result
  always @(negedge clk) begin
    logic [NB-1:0] e;
    int            l;
    if (!reset) begin
      if (cmp_start_o) begin
        if (exp_code.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexp_start: code %0h issued, none expected", dac_code_o);
        end else begin
          e = exp_code.pop_front();
          chk("trial_code", dac_code_o, e);
        end
      end
      if (data_valid_o) begin
        if (exp_data.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexp_valid: data %0h presented, none expected", data_o);
        end else begin
          e = exp_data.pop_front();
          l = exp_lat.pop_front();
          chk("result", data_o, e);
          if (l >= 0) chk("latency", cyc, l);
        end
      end
      if (overrun_o) obs_ovr++;
      if (timeout_o) obs_tmo++;
    end
  end

  task automatic rise_phase(input logic [NB-1:0] vin, input logic [NB-1:0] hold,
                            input int dly, input bit stray);
    @(posedge clk); #1;
    sample      = 1'b1;
    win_id++;
    vin_cur     = vin;
    hold_mask   = hold;
    rsp_delay   = dly;
    stray_trial = stray;
  endtask

  // Drops the sample phase and queues the reference search's trials/result
  task automatic fall_phase(input int ncodes, input bit push_data, input bit lat);
    logic [NB-1:0] res, trial, one;
    @(posedge clk); #1;
    sample   = 1'b0;
    fall_cyc = cyc;
    res      = '0;
    one      = NB'(1);
    for (int b = NB - 1; b >= 0; b--) begin
      trial = res | (one << b);
      if (NB - 1 - b < ncodes) exp_code.push_back(trial);
      if (!hold_mask[b] && vin_cur >= trial) res = trial;
    end
    if (push_data) begin
      exp_data.push_back(res);
      exp_lat.push_back(lat ? fall_cyc + 2 * NB + 1 : -1);
      last_data = res;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_data.size() != 0 || exp_code.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_data.size() + exp_code.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_starts(input int target);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (starts == target) break;
    end
  endtask

  task automatic stray_idle();
    @(posedge clk); #1;
    stray_rdy = 1'b1;
    stray_out = 1'b1;
    @(posedge clk); #1;
    stray_rdy = 1'b0;
    stray_out = 1'b0;
    @(negedge clk);
    chk("idle_code", dac_code_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code"}, dac_code_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_start"}, cmp_start_o, 0);
    chk({tag, "_valid"}, data_valid_o, 0);
    chk({tag, "_ovr"}, overrun_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
  endtask

  initial begin : driver
    int dly;
    sample    = 1'b0;
    reset     = 1'b1;
    stray_rdy = 1'b0;
    stray_out = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Vin 1011 with immediate ready: trials 1000,1100,1010,1011, 9-cycle latency
    rise_phase(4'b1011, 4'b0000, 1, 1'b0);
    fall_phase(NB, 1'b1, 1'b1);
    wait_done();

    // Back-to-back windows: new rise lands in the DONE cycle
    rise_phase(4'b0000, 4'b0000, 1, 1'b0);
    fall_phase(NB, 1'b1, 1'b1);
    repeat (2 * NB + 1) @(posedge clk);
    #1;
    sample = 1'b1; win_id++; vin_cur = 4'b1111;
    @(negedge clk);
    chk("b2b_valid", data_valid_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_busy", busy_o, 1);
    fall_phase(NB, 1'b1, 1'b1);
    wait_done();

    // Abort: new sample phase while bit 2 is waiting for its decision
    rise_phase(4'b1101, 4'b0100, 1, 1'b0);
    fall_phase(2, 1'b0, 1'b0);
    wait_starts(2);
    exp_ovr++;
    rise_phase(4'b0110, 4'b0000, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("ovr_pulse", overrun_o, 1);
    chk("ovr_data_kept", data_o, last_data);
    chk("ovr_code_clr", dac_code_o, 0);
    fall_phase(NB, 1'b1, 1'b1);
    wait_done();

    // Slow comparator plus a wrong-valued ready pulse during TRIAL
    rise_phase(4'b1001, 4'b0000, 5, 1'b1);
    fall_phase(NB, 1'b1, 1'b0);
    wait_done();
    stray_idle();

    // Randomized windows
    for (int k = 0; k < 12; k++) begin
      dly = int'($urandom_range(1, 4));
      rise_phase(NB'($urandom_range(0, 15)), 4'b0000, dly, 1'($urandom_range(0, 1)));
      fall_phase(NB, 1'b1, dly == 1);
      wait_done();
      stray_idle();
    end

    // Reset while bit 1 is waiting; stray ready afterwards must do nothing
    rise_phase(4'b1110, 4'b0010, 1, 1'b0);
    fall_phase(3, 1'b0, 1'b0);
    wait_starts(3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_data = '0;
    @(negedge clk);
    chk_reset_vals("midrst");
    stray_idle();
    chk("midrst_data", data_o, 0);

`ifdef SAR_LOGIC_TIMEOUT_EN
    // MSB decision withheld: timeout forces it to 0, rest resolves normally
    exp_tmo++;
    rise_phase(4'b0111, 4'b1000, 1, 1'b0);
    fall_phase(NB, 1'b1, 1'b0);
    wait_done();
`endif

    chk("overrun_count", obs_ovr, exp_ovr);
    chk("timeout_count", obs_tmo, exp_tmo);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
